reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 30 +++
 rtl/reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and helpers for the 27 MHz reset sequencer.
//   seq_state_e : sequencer states, in the order the sequence walks them.
//   cnt_width() : width of the single shared sequencing counter. It is
//                 $clog2 of the largest cycle count in use, plus one. The
//                 timeout count only takes part when the timeout feature is
//                 built in.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    MEM_RST,
    MEM_WAIT,
    CORE_RST,
    RUN
  } seq_state_e;

  function automatic int cnt_width(input int lock_c, input int mem_c,
                                   input int core_c, input int tmo_c,
                                   input bit use_tmo);
    int m;
    m = lock_c;
    if (mem_c  > m)            m = mem_c;
    if (core_c > m)            m = core_c;
    if (use_tmo && tmo_c > m)  m = tmo_c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for a level that is
// asynchronous to i_clk. o_q follows i_d with 2 edges of latency.
// Ports:
//   i_clk   destination clock
//   i_reset synchronous active-high reset (clears both flops to 0)
//   i_d     asynchronous input level
//   o_q     synchronised level
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on / lock-loss reset sequencer for the 27 MHz
// domain. It waits for a stable PLL lock, then pulses the memory-controller
// reset and waits for SDRAM init. After that it holds the core in reset for
// a fixed time and then reports ready.
// Optional feature: define RESET_SEQ_TIMEOUT_EN to bound the wait for
// mem_init_done. On expiry it sets a sticky timeout_err and retries from
// MEM_RST. Without the macro, timeout_err is tied to 0.
// Ports:
//   clk           27 MHz PLL output clock
//   reset         synchronous active-high reset
//   pll_lock      PLL lock, asynchronous (synchronised internally)
//   mem_init_done memory controller init-complete level
//   rst_mem       active-high memory-controller reset (registered)
//   rst_core      active-high core reset (registered)
//   ready         system running (registered)
//   timeout_err   sticky memory-init timeout flag
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MEM_RST_CYCLES     = 16,
  parameter int CORE_RST_CYCLES    = 64,
  parameter int MEM_TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic mem_init_done,
  output logic rst_mem,
  output logic rst_core,
  output logic ready,
  output logic timeout_err
);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, MEM_RST_CYCLES,
                                CORE_RST_CYCLES, MEM_TIMEOUT_CYCLES, TMO_EN);

  // A phase ends on the edge where the counter holds N-1. That way each
  // phase lasts exactly N edges from the edge that entered it.
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_RST_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LAST = CW'(CORE_RST_CYCLES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST  = CW'(MEM_TIMEOUT_CYCLES - 1);
`endif

  logic       w_lock_s;
  seq_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic       r_rst_mem, r_rst_core, r_ready;

  sync_2ff u_lock_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

`ifdef RESET_SEQ_TIMEOUT_EN
  logic r_tmo, w_tmo_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef RESET_SEQ_TIMEOUT_EN
    w_tmo_nxt   = r_tmo;
`endif
    // Lock loss beats every other transition. In WAIT_LOCK it just
    // restarts the stability count.
    if (!w_lock_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (r_cnt == LOCK_LAST) begin
            w_state_nxt = MEM_RST;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        MEM_RST: begin
          if (r_cnt == MEM_LAST) begin
            w_state_nxt = MEM_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_init_done) begin
            w_state_nxt = CORE_RST;
            w_cnt_nxt   = '0;
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (r_cnt == TMO_LAST) begin
            w_state_nxt = MEM_RST;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
`endif
        end
        CORE_RST: begin
          if (r_cnt == CORE_LAST) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        RUN:     w_cnt_nxt = '0;
        default: begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state, so they move on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_rst_mem  <= 1'b1;
      r_rst_core <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rst_mem  <= (w_state_nxt == WAIT_LOCK) || (w_state_nxt == MEM_RST);
      r_rst_core <= (w_state_nxt != RUN);
      r_ready    <= (w_state_nxt == RUN);
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) r_tmo <= 1'b0;
    else       r_tmo <= w_tmo_nxt;
  end
  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0;
`endif

  assign rst_mem  = r_rst_mem;
  assign rst_core = r_rst_core;
  assign ready    = r_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with
// LOCK_STABLE_CYCLES=8, MEM_RST_CYCLES=4, CORE_RST_CYCLES=6,
// MEM_TIMEOUT_CYCLES=20. Outputs are checked as the 4-bit vector
// {rst_mem, rst_core, ready, timeout_err}.
// Edge numbering: edge 0 is the last edge that samples reset=1. An input
// driven just after edge k is first sampled at edge k+1.
// Set RESET_SEQ_TIMEOUT_EN to exercise the timeout build.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset, pll_lock, mem_init_done;
  logic rst_mem, rst_core, ready, timeout_err;
  logic [3:0] w_o;

  int n_tot = 0;
  int n_bad = 0;
  int ed    = 0;

  localparam logic [3:0] O_LOCK = 4'b1100;  // WAIT_LOCK / MEM_RST
  localparam logic [3:0] O_WAIT = 4'b0100;  // MEM_WAIT / CORE_RST
  localparam logic [3:0] O_RUN  = 4'b0010;  // RUN
  localparam logic [3:0] O_TMO  = 4'b0001;  // timeout_err bit

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .MEM_RST_CYCLES     (4),
    .CORE_RST_CYCLES    (6),
    .MEM_TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .mem_init_done (mem_init_done),
    .rst_mem       (rst_mem),
    .rst_core      (rst_core),
    .ready         (ready),
    .timeout_err   (timeout_err)
  );

  assign w_o = {rst_mem, rst_core, ready, timeout_err};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%b exp=%b", tag, ed, got, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ed++;
    end
  endtask

  task automatic step_to(input int t);
    while (ed < t) step(1);
  endtask

  task automatic do_reset(input logic lk, input logic md);
    reset = 1'b1; pll_lock = lk; mem_init_done = md;
    step(1);
    ed = 0;
    chk("reset_state", w_o, O_LOCK);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pll_lock = 1'b0; mem_init_done = 1'b0;
    step(2);

    // Nominal: lock from release, mem_init_done first sampled at edge 30.
    do_reset(1'b1, 1'b0);
    step_to(13); chk("nom_rstmem_hold", w_o, O_LOCK);
    step_to(14); chk("nom_rstmem_fall", w_o, O_WAIT);
    step_to(29); chk("nom_mem_wait", w_o, O_WAIT);
    mem_init_done = 1'b1;
    step_to(35); chk("nom_core_hold", w_o, O_WAIT);
    step_to(36); chk("nom_run", w_o, O_RUN);

    // Lock loss in RUN: first sampled low at edge 41, reaction at 43.
    step_to(40); pll_lock = 1'b0;
    step_to(42); chk("loss_still_run", w_o, O_RUN);
    step_to(43); chk("loss_react", w_o, O_LOCK);
    pll_lock = 1'b1;  // relock first sampled at 44, like a release at 43
    step_to(56); chk("relock_rstmem_hold", w_o, O_LOCK);
    step_to(57); chk("relock_rstmem_fall", w_o, O_WAIT);
    // mem_init_done already high: CORE_RST at 58, RUN at 64
    step_to(63); chk("relock_core_hold", w_o, O_WAIT);
    step_to(64); chk("relock_run", w_o, O_RUN);

    // Lock unstable: low for one cycle after 5 high, last rise after edge 6.
    do_reset(1'b1, 1'b0);
    step_to(5); pll_lock = 1'b0;
    step_to(6); pll_lock = 1'b1;
    step_to(14); chk("unst_no_early_fall", w_o, O_LOCK);
    step_to(19); chk("unst_rstmem_hold", w_o, O_LOCK);
    step_to(20); chk("unst_rstmem_fall", w_o, O_WAIT);

    // Reset mid-sequence: mem_init_done high throughout, CORE_RST at 15..20.
    do_reset(1'b1, 1'b1);
    step_to(14); chk("mid_mem_wait", w_o, O_WAIT);
    step_to(17); reset = 1'b1;
    step_to(18); chk("mid_reset", w_o, O_LOCK);
    reset = 1'b0; ed = 0;  // edge 18 becomes the new edge 0
    step_to(13); chk("mid_rstmem_hold", w_o, O_LOCK);
    step_to(14); chk("mid_rstmem_fall", w_o, O_WAIT);
    step_to(20); chk("mid_core_hold", w_o, O_WAIT);
    step_to(21); chk("mid_run", w_o, O_RUN);

`ifdef RESET_SEQ_TIMEOUT_EN
    // Timeout: MEM_WAIT from 14, expiry at 34, MEM_RST 34..37, MEM_WAIT at 38.
    do_reset(1'b1, 1'b0);
    step_to(33); chk("tmo_before", w_o, O_WAIT);
    step_to(34); chk("tmo_set", w_o, O_LOCK | O_TMO);
    step_to(37); chk("tmo_memrst", w_o, O_LOCK | O_TMO);
    step_to(38); chk("tmo_retry_wait", w_o, O_WAIT | O_TMO);
    mem_init_done = 1'b1;
    step_to(45); chk("tmo_sticky_run", w_o, O_RUN | O_TMO);
    do_reset(1'b1, 1'b0);  // reset clears the sticky flag
    step_to(14); chk("tmo_cleared", w_o, O_WAIT);
`else
    // No timeout: MEM_WAIT holds for 1000 cycles with timeout_err=0.
    do_reset(1'b1, 1'b0);
    step_to(14);
    for (int i = 1; i <= 10; i++) begin
      step_to(14 + i * 100);
      chk("notmo_wait", w_o, O_WAIT);
    end
    mem_init_done = 1'b1;  // first sampled at 1015, RUN at 1021
    step_to(1020); chk("notmo_core_hold", w_o, O_WAIT);
    step_to(1021); chk("notmo_run", w_o, O_RUN);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
